led_matrix_scanner: RTL
=======================

Name: led_matrix_scanner

Overview:
- Downstream display stage of the pong datapath. Consumes the ball's 4-bit screen position and the two paddle positions.
- Renders them onto a 16x16 single-colour LED matrix. The matrix is driven row by row through a serial column shift register (data/clock/latch), a 4-bit row address and a blanking line.
- Inputs are frame-snapshotted so the picture never tears mid-frame.

Parameters:
PAD_LEN, 3, paddle height in pixels (1..8)
HOLD_CYCLES, 16, extra display cycles per row after latch (>=1)

Ports:
clk  input  1  system clock (same 2000Hz domain as ball motion)
reset  input  1  synchronous, active-high
ball_x  input  4  ball column, 0 = left
ball_y  input  4  ball row, 0 = top
pad_l  input  4  top row of left paddle (column 0)
pad_r  input  4  top row of right paddle (column 15)
col_data  output  1  serial column bit to shift register
col_clk  output  1  shift clock, data sampled by driver on rising edge
col_latch  output  1  transfers shift register to column outputs
row  output  4  address of row currently displayed
blank  output  1  1 = all LEDs off
frame_sync  output  1  1-cycle pulse when the input snapshot is taken

Behaviour:
- All outputs registered.
- Reset values: col_data=0, col_clk=0, col_latch=0, row=0, blank=1, frame_sync=0. Internal load_row=0, state=SHIFT, shift cycle k=0.
- Reset mid-operation returns to these values on the next edge; any partial row is abandoned.
- Snapshot: bx, by, lp, rp capture ball_x, ball_y, pad_l, pad_r on the first SHIFT cycle of load_row 0.
  - This occurs on the first cycle after reset deasserts and after every row-15 HOLD.
  - frame_sync=1 in that same cycle.
  - Pixels for the whole frame use only snapshot values.
- Pixel(r,c)=1 iff any of:
  - c==bx and r==by
  - c==0 and lp <= r <= lp+PAD_LEN-1
  - c==15 and rp <= r <= rp+PAD_LEN-1
- Comparisons use 5-bit arithmetic. Paddle rows beyond 15 are clipped, not wrapped. Ball and paddle overlap simply ORs.
- State SHIFT, 32 cycles, k=0..31:
  - col_clk = k[0].
  - col_data = Pixel(load_row, 15-(k>>1)), held stable across both cycles of each bit. Column 15 goes first.
  - col_latch=0.
  - blank and row keep their previous values, so the previous row stays lit while the next one shifts. After reset, blank stays 1.
  - After k=31 -> LATCH.
- State LATCH, 2 cycles:
  - Cycle L0: blank=1, col_latch=1, col_clk=0.
  - Cycle L1: blank=1, col_latch=0, row <= load_row.
  - Then -> HOLD.
- State HOLD, HOLD_CYCLES cycles:
  - blank=0, col_clk=0, col_latch=0.
  - Last cycle: load_row <= load_row+1, wrapping 15->0, then -> SHIFT with k=0.
- Row period = 34 + HOLD_CYCLES cycles (50 at default). Frame period = 16x that (800 at default).
- Input changes outside the snapshot cycle have no effect until the next frame.
- Simultaneous snapshot and input change: the value present at that clock edge is captured.

Test Plan:
- Reset held 5 cycles, then released -> during and after reset blank=1, row=0, col_clk=0. frame_sync=1 on exactly the first cycle after release. blank stays 1 until the first L1 (cycle 33 after release), and is 0 from cycle 34.
- ball=(5,0), pad_l=8, pad_r=8 -> row-0 serial stream, column 15 first, is 0000000000100000. Each bit is stable for 2 cycles with col_clk rising mid-bit. col_latch pulses once at cycle 32.
- pad_l=14, PAD_LEN=3, ball=(7,7) -> rows 14 and 15 have column-0 bit set (last bit shifted). No column-0 bit appears in rows 0 or 1, confirming clipping without wrap.
- Change ball_x from 3 to 9 during row 6 of a frame -> remaining rows of that frame still show column 3. The next frame (after frame_sync) shows column 9. Consecutive frame_sync pulses are 800 cycles apart.
- Ball at (0,9) with pad_l=8 -> row 9 column 0 = 1 (OR); row 10 column 0 = 1; row 11 = 0.
- Assert reset during SHIFT k=17 of row 4 -> next cycle all outputs at reset values. After release, row-0 shifting restarts with a new snapshot and frame_sync.

Source files
------------

// File: rtl/led_matrix_scanner.sv
// led_matrix_scanner: renders the pong ball and both paddles onto a 16x16 single-colour LED
// matrix driven row by row. Each row is shifted out serially (column 15 first), latched, then
// displayed for HOLD_CYCLES cycles. Ball/paddle inputs are snapshotted once per frame so a frame
// never tears.
//
// Ports:
//   clk         system clock
//   reset       synchronous, active-high
//   ball_x/y    ball column / row (0 = left / top)
//   pad_l/pad_r top row of left (column 0) / right (column 15) paddle
//   col_data    serial column bit, stable across both halves of each bit
//   col_clk     shift clock, rising mid-bit
//   col_latch   1-cycle pulse transferring the shift register to the column drivers
//   row         row address currently displayed
//   blank       1 = all LEDs off
//   frame_sync  1-cycle pulse in the cycle the input snapshot is taken
module led_matrix_scanner #(
  parameter int unsigned PAD_LEN     = 3,
  parameter int unsigned HOLD_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] ball_x,
  input  logic [3:0] ball_y,
  input  logic [3:0] pad_l,
  input  logic [3:0] pad_r,
  output logic       col_data,
  output logic       col_clk,
  output logic       col_latch,
  output logic [3:0] row,
  output logic       blank,
  output logic       frame_sync
);

  // One counter serves SHIFT (0..31), LATCH (0..1) and HOLD (0..HOLD_CYCLES-1).
  localparam int unsigned CntW = (HOLD_CYCLES > 32) ? $clog2(HOLD_CYCLES) : 5;

  typedef enum logic [1:0] {StShift, StLatch, StHold} state_e;

  // state_q/cnt_q describe the cycle that begins at the next edge; outputs are registered
  // at that edge, so the output values always match the cycle's phase.
  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic [3:0]      load_row_q;
  logic [3:0]      bx_q, by_q, lp_q, rp_q;

  // Row/column comparisons widened to 5 bits so paddles near the bottom clip instead of wrap.
  function automatic logic pixel(input logic [3:0] r, input logic [3:0] c,
                                 input logic [3:0] bx, input logic [3:0] by,
                                 input logic [3:0] lp, input logic [3:0] rp);
    logic [4:0] r5, lp_top, lp_bot, rp_top, rp_bot;
    r5     = {1'b0, r};
    lp_top = {1'b0, lp};
    rp_top = {1'b0, rp};
    lp_bot = lp_top + 5'(PAD_LEN - 1);
    rp_bot = rp_top + 5'(PAD_LEN - 1);
    pixel  = ((c == bx) && (r == by)) ||
             ((c == 4'd0) && (r5 >= lp_top) && (r5 <= lp_bot)) ||
             ((c == 4'd15) && (r5 >= rp_top) && (r5 <= rp_bot));
  endfunction

  logic       snap;
  logic [3:0] bx_e, by_e, lp_e, rp_e;
  logic [3:0] shift_col;

  always_comb begin
    snap      = (state_q == StShift) && (cnt_q == '0) && (load_row_q == 4'd0);
    // In the snapshot cycle the bit being output comes straight from the live inputs,
    // which are the values being captured at this same edge.
    bx_e      = snap ? ball_x : bx_q;
    by_e      = snap ? ball_y : by_q;
    lp_e      = snap ? pad_l  : lp_q;
    rp_e      = snap ? pad_r  : rp_q;
    shift_col = 4'd15 - cnt_q[4:1];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StShift;
      cnt_q      <= '0;
      load_row_q <= 4'd0;
      bx_q       <= 4'd0;
      by_q       <= 4'd0;
      lp_q       <= 4'd0;
      rp_q       <= 4'd0;
      col_data   <= 1'b0;
      col_clk    <= 1'b0;
      col_latch  <= 1'b0;
      row        <= 4'd0;
      blank      <= 1'b1;
      frame_sync <= 1'b0;
    end else begin
      col_data   <= 1'b0;
      col_clk    <= 1'b0;
      col_latch  <= 1'b0;
      frame_sync <= 1'b0;
      unique case (state_q)
        StShift: begin
          if (snap) begin
            bx_q       <= ball_x;
            by_q       <= ball_y;
            lp_q       <= pad_l;
            rp_q       <= pad_r;
            frame_sync <= 1'b1;
          end
          // blank and row hold: the previous row stays lit while this one shifts.
          col_clk  <= cnt_q[0];
          col_data <= pixel(load_row_q, shift_col, bx_e, by_e, lp_e, rp_e);
          if (cnt_q == CntW'(31)) begin
            state_q <= StLatch;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StLatch: begin
          blank <= 1'b1;
          if (cnt_q == '0) begin
            col_latch <= 1'b1;
            cnt_q     <= CntW'(1);
          end else begin
            row     <= load_row_q;
            state_q <= StHold;
            cnt_q   <= '0;
          end
        end
        StHold: begin
          blank <= 1'b0;
          if (cnt_q == CntW'(HOLD_CYCLES - 1)) begin
            load_row_q <= load_row_q + 4'd1;
            state_q    <= StShift;
            cnt_q      <= '0;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        default: begin
          state_q <= StShift;
          cnt_q   <= '0;
        end
      endcase
    end
  end

endmodule
